// File: rtl/vram_slot_arbiter_if.sv
// CPU-side request/acknowledge bus of the video RAM slot arbiter.
// master = ISA CPU bridge, slave = arbiter.
interface vram_slot_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [13:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_wait;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_wait
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_wait
    );
endinterface

// File: rtl/vram_slot_arbiter.sv
// Time-slot scheduler sharing one single-port VRAM between CRTC fetch and CPU accesses.
// Optional macro VRAM_BLANK_FREE_EN: during blanking, fetch slots are handed to the CPU.
module vram_slot_arbiter #(
    parameter int unsigned PHASES      = 8,
    parameter logic [7:0]  RDATA_RESET = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 divclk,
    input  logic [13:0]          crtc_addr,
    input  logic                 display_enable,
    vram_slot_arbiter_if.slave   cpu,
    output logic [13:0]          vram_addr,
    output logic                 vram_we,
    output logic [7:0]           vram_dout,
    input  logic [7:0]           vram_din,
    output logic [7:0]           char_byte,
    output logic [7:0]           attr_byte,
    output logic                 fetch_valid
);

    localparam int unsigned    PW      = $clog2(PHASES);
    localparam logic [PW-1:0]  PH_LAST = PW'(PHASES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_RD,
        S_ACK,
        S_REL
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q;
    logic          blank;
    logic          fetch_slot, cpu_slot;
    logic          lat_we;
    logic [13:0]   lat_addr, addr_hold;
    logic [7:0]    lat_wdata, char_q;

    logic unused_msb;
    assign unused_msb = crtc_addr[13];

`ifdef VRAM_BLANK_FREE_EN
    logic blank_q;

    // Blanking decision is taken once per character period, with divclk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= 1'b0;
        end else if (phase_q == PH_LAST) begin
            blank_q <= ~display_enable;
        end
    end

    assign blank = blank_q;
`else
    logic unused_de;
    assign unused_de = display_enable;
    assign blank     = 1'b0;
`endif

    always_comb begin
        fetch_slot = !blank && ((phase_q == PW'(0)) || (phase_q == PW'(2)));
        cpu_slot   = (phase_q == PW'(4)) || (phase_q == PW'(6)) ||
                     (blank && ((phase_q == PW'(0)) || (phase_q == PW'(2))));
    end

    // Next-state and RAM port drive; idle phases keep the last address on the bus.
    always_comb begin
        state_d   = state_q;
        vram_addr = addr_hold;
        vram_we   = 1'b0;
        vram_dout = 8'h00;
        if (fetch_slot) begin
            vram_addr = {crtc_addr[12:0], phase_q[1]};
        end
        unique case (state_q)
            S_IDLE: if (cpu.cpu_req) state_d = S_PEND;
            S_PEND: begin
                if (cpu_slot) begin
                    vram_addr = lat_addr;
                    vram_we   = lat_we;
                    vram_dout = lat_we ? lat_wdata : 8'h00;
                    state_d   = lat_we ? S_ACK : S_RD;
                end
            end
            S_RD:   state_d = S_ACK;
            S_ACK:  state_d = S_REL;
            S_REL:  if (!cpu.cpu_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu.cpu_wait = cpu.cpu_req &&
                          ((state_q == S_IDLE) || (state_q == S_PEND) || (state_q == S_RD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= '0;
            divclk        <= 1'b0;
            state_q       <= S_IDLE;
            cpu.cpu_ack   <= 1'b0;
            cpu.cpu_rdata <= RDATA_RESET;
            addr_hold     <= 14'h0000;
            lat_we        <= 1'b0;
            lat_addr      <= 14'h0000;
            lat_wdata     <= 8'h00;
            char_q        <= 8'h00;
            char_byte     <= RDATA_RESET;
            attr_byte     <= RDATA_RESET;
            fetch_valid   <= 1'b0;
        end else begin
            phase_q     <= (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
            divclk      <= (phase_q == PW'(PHASES - 2));
            state_q     <= state_d;
            cpu.cpu_ack <= (state_d == S_ACK);
            addr_hold   <= vram_addr;
            fetch_valid <= (phase_q == PW'(3));
            if ((state_q == S_IDLE) && cpu.cpu_req) begin
                lat_we    <= cpu.cpu_we;
                lat_addr  <= cpu.cpu_addr;
                lat_wdata <= cpu.cpu_wdata;
            end
            if (state_q == S_RD) begin
                cpu.cpu_rdata <= vram_din;
            end
            if (phase_q == PW'(1)) begin
                char_q <= vram_din;
            end
            if (phase_q == PW'(3)) begin
                char_byte <= blank ? 8'h00 : char_q;
                attr_byte <= blank ? 8'h00 : vram_din;
            end
        end
    end

endmodule
